pixart_i2c_target: RTL and testbench

I2C target that emulates the PixArt IR camera's register interface, answering the `camera` initiator on the same two-wire bus. It is used for bring-up and simulation of the tracking pipeline without the physical sensor. It accepts configuration writes, which it reports to the parent as strobes. It returns a 16-byte blob report built from parent-supplied X/Y coordinates. It sits in `top` beside `camera`, oversampling SCL/SDA on the system clock.

---
 rtl/pixart_i2c_target.sv | 214 +++++++++++++++++++++
 tb/tb_pixart_i2c_target.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixart_i2c_target.sv
// I2C target emulating the PixArt IR camera register map: configuration
// writes are reported as strobes, reads return a 16-byte blob report.
`timescale 1ns/1ps
module pixart_i2c_target #(
  parameter logic [6:0] ADDR       = 7'h58,
  parameter logic [7:0] REPORT_REG = 8'h36
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [9:0] blob_x,
  input  logic [9:0] blob_y,
  input  logic [3:0] blob_size,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK
  } state_t;

  state_t state_q, state_d;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic       rise_q, fall_q, start_q, stop_q, sda_bit;

  logic [7:0] shreg, ptr;
  logic [3:0] cnt;
  logic [4:0] k;
  logic       rd_q, rpt_sel;
  logic [9:0] snap_x, snap_y;
  logic [3:0] snap_s;

  logic       scl_s, sda_s, addr_match;
  logic [4:0] k_inc;
  logic [7:0] byte_first, byte_next;

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  // Synchronizers reset to the idle-bus level so reset release creates no edge.
  // NOTE: all sequential state uses non-blocking (<=) assignments so every flop
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      sda_bit  <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      rise_q   <= scl_s & ~scl_d;
      fall_q   <= ~scl_s & scl_d;
      start_q  <= scl_s & scl_d & sda_d & ~sda_s;
      stop_q   <= scl_s & scl_d & ~sda_d & sda_s;
      sda_bit  <= sda_s;
    end
  end

  function automatic logic [7:0] report_byte(input logic [4:0] idx, input logic sel,
                                             input logic [9:0] x, input logic [9:0] y,
                                             input logic [3:0] s);
    logic [7:0] b;
    b = 8'h00;
    if (sel) begin
      if (idx == 5'd1)      b = x[7:0];
      else if (idx == 5'd2) b = y[7:0];
      else if (idx == 5'd3) b = {y[9:8], x[9:8], s};
      else if (idx >= 5'd4 && idx <= 5'd12) b = 8'hFF;
    end
    return b;
  endfunction

  assign addr_match = (shreg[7:1] == ADDR);
  assign k_inc      = (k == 5'd16) ? k : k + 5'd1;
  assign byte_first = report_byte(5'd0, rpt_sel, snap_x, snap_y, snap_s);
  assign byte_next  = report_byte(k_inc, rpt_sel, snap_x, snap_y, snap_s);
  assign busy       = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (stop_q) begin
      state_d = S_IDLE;
    end else if (start_q) begin
      state_d = S_ADDR;
    end else begin
      unique case (state_q)
        S_IDLE:     state_d = S_IDLE;
        S_ADDR:     if (fall_q && cnt == 4'd8) state_d = addr_match ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK: if (fall_q) state_d = rd_q ? S_RD_BYTE : S_PTR;
        S_PTR:      if (fall_q && cnt == 4'd8) state_d = S_PTR_ACK;
        S_PTR_ACK:  if (fall_q) state_d = S_WR_BYTE;
        S_WR_BYTE:  if (fall_q && cnt == 4'd8) state_d = S_WR_ACK;
        S_WR_ACK:   if (fall_q) state_d = S_WR_BYTE;
        S_RD_BYTE:  if (fall_q && cnt == 4'd8) state_d = S_RD_ACK;
        S_RD_ACK: begin
          if (rise_q && sda_bit) state_d = S_IDLE;
          else if (fall_q)       state_d = S_RD_BYTE;
        end
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sda_oe   <= 1'b0;
      reg_wr   <= 1'b0;
      reg_addr <= 8'h00;
      reg_data <= 8'h00;
      ptr      <= 8'h00;
      shreg    <= 8'h00;
      cnt      <= 4'd0;
      k        <= 5'd0;
      rd_q     <= 1'b0;
      rpt_sel  <= 1'b0;
      snap_x   <= 10'h000;
      snap_y   <= 10'h000;
      snap_s   <= 4'h0;
    end else begin
      reg_wr <= 1'b0;
      if (stop_q || start_q) begin
        sda_oe <= 1'b0;
        cnt    <= 4'd0;
      end else begin
        unique case (state_q)
          S_ADDR, S_PTR, S_WR_BYTE: begin
            if (rise_q && cnt != 4'd8) begin
              shreg <= {shreg[6:0], sda_bit};
              cnt   <= cnt + 4'd1;
              if (state_q == S_WR_BYTE && cnt == 4'd7) begin
                reg_wr   <= 1'b1;
                reg_addr <= ptr;
                reg_data <= {shreg[6:0], sda_bit};
                ptr      <= ptr + 8'd1;
              end
            end
            if (fall_q && cnt == 4'd8) begin
              cnt <= 4'd0;
              if (state_q != S_ADDR) begin
                sda_oe <= 1'b1;
                if (state_q == S_PTR) ptr <= shreg;
              end else if (addr_match) begin
                sda_oe <= 1'b1;
                rd_q   <= shreg[0];
                // Freeze the blob inputs so a multi-byte read is coherent.
                if (shreg[0]) begin
                  snap_x  <= blob_x;
                  snap_y  <= blob_y;
                  snap_s  <= blob_size;
                  rpt_sel <= (ptr == REPORT_REG);
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (fall_q) begin
              if (rd_q) begin
                k      <= 5'd0;
                shreg  <= byte_first;
                sda_oe <= ~byte_first[7];
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
          S_PTR_ACK, S_WR_ACK: begin
            if (fall_q) sda_oe <= 1'b0;
          end
          S_RD_BYTE: begin
            if (rise_q && cnt != 4'd8) cnt <= cnt + 4'd1;
            if (fall_q && cnt == 4'd8) begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
            end else if (fall_q && cnt != 4'd0) begin
              sda_oe <= ~shreg[6];
              shreg  <= {shreg[6:0], 1'b0};
            end
          end
          S_RD_ACK: begin
            if (fall_q) begin
              k      <= k_inc;
              shreg  <= byte_next;
              sda_oe <= ~byte_next[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixart_i2c_target.sv
// Scoreboard bench for pixart_i2c_target: a bit-banged initiator drives the
// bus, expected strobes and read bytes are queued and checked by monitors.
`timescale 1ns/1ps
module tb_pixart_i2c_target;

  localparam int Q = 60;  // quarter SCL period in ns (SCL = 24 clk)

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [9:0] blob_x = 10'h000;
  logic [9:0] blob_y = 10'h000;
  logic [3:0] blob_size = 4'h0;
  logic       reg_wr;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [15:0] e_wr;
  logic [7:0]  e_rd;
  logic [7:0]  rd_last;
  event        rd_done;

  assign sda_line = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  pixart_i2c_target dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .blob_x    (blob_x),
    .blob_y    (blob_y),
    .blob_size (blob_size),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: every reg_wr pulse must match the head of the queue.
  always @(negedge clk) begin
    if (reg_wr === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got %h/%h expected none", reg_addr, reg_data);
      end else begin
        e_wr = exp_wr.pop_front();
        check("strobe addr/data", {16'h0, reg_addr, reg_data}, {16'h0, e_wr});
      end
    end
  end

  // Read monitor: every byte clocked out of the target is scored in order.
  always @(rd_done) begin
    if (exp_rd.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_read: got %h expected none", rd_last);
    end else begin
      e_rd = exp_rd.pop_front();
      check("read byte", {24'h0, rd_last}, {24'h0, e_rd});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic i2c_start();
    sda_drv = 1'b1; #Q;
    scl = 1'b1;     #Q;
    sda_drv = 1'b0; #Q;
    scl = 1'b0;     #Q;
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; #Q;
    scl = 1'b1;     #Q;
    sda_drv = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_drv = b; #Q;
    scl = 1'b1;  #(2*Q);
    scl = 1'b0;  #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_drv = 1'b1; #Q;
    scl = 1'b1;     #Q;
    b = sda_line;   #Q;
    scl = 1'b0;     #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic line;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(line);
    ack = ~line;
  endtask

  task automatic read_byte(input logic nack);
    logic [7:0] d;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
    rd_last = d;
    -> rd_done;
  endtask

  logic       ack;
  logic       bit_v;
  logic [7:0] rpt[16];

  initial begin
    rpt = '{8'h00, 8'hA5, 8'h7C, 8'h63, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};

    #23 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset sda_oe", {31'h0, sda_oe}, 0);
    check("reset busy", {31'h0, busy}, 0);
    check("reset reg_wr", {31'h0, reg_wr}, 0);
    check("reset reg_addr/data", {16'h0, reg_addr, reg_data}, 0);

    // Configuration write: two strobes with auto-incrementing pointer.
    exp_wr.push_back(16'h3001);
    exp_wr.push_back(16'h3108);
    i2c_start();
    write_byte(8'hB0, ack); check("ack B0", {31'h0, ack}, 1);
    check("busy in transfer", {31'h0, busy}, 1);
    write_byte(8'h30, ack); check("ack ptr 30", {31'h0, ack}, 1);
    write_byte(8'h01, ack); check("ack data 01", {31'h0, ack}, 1);
    write_byte(8'h08, ack); check("ack data 08", {31'h0, ack}, 1);
    i2c_stop();
    repeat (10) @(posedge clk);
    #1 check("busy after stop", {31'h0, busy}, 0);

    // Full report read via repeated START.
    blob_x = 10'h2A5; blob_y = 10'h17C; blob_size = 4'h3;
    i2c_start();
    write_byte(8'hB0, ack); check("ack B0 rd setup", {31'h0, ack}, 1);
    write_byte(8'h36, ack); check("ack ptr 36", {31'h0, ack}, 1);
    i2c_start();
    write_byte(8'hB1, ack); check("ack B1", {31'h0, ack}, 1);
    for (int i = 0; i < 16; i++) begin
      exp_rd.push_back(rpt[i]);
      read_byte(i == 15);
    end
    i2c_stop();

    // Second read with the pointer left at 0x36; blob_x changes mid-read.
    i2c_start();
    write_byte(8'hB1, ack); check("ack B1 coherent", {31'h0, ack}, 1);
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back(rpt[i]);
      if (i == 2) blob_x = 10'h155;
      read_byte(i == 3);
    end
    i2c_stop();
    blob_x = 10'h2A5;

    // Wrong address: no ACK, not busy, no strobe.
    i2c_start();
    write_byte(8'hA0, ack); check("nack A0", {31'h0, ack}, 0);
    check("busy after mismatch", {31'h0, busy}, 0);
    write_byte(8'h55, ack); check("ignored byte", {31'h0, ack}, 0);
    i2c_stop();

    // Valid transaction afterwards with pointer wrap 0xFF -> 0x00.
    exp_wr.push_back(16'hFFAA);
    exp_wr.push_back(16'h00BB);
    i2c_start();
    write_byte(8'hB0, ack); check("ack B0 wrap", {31'h0, ack}, 1);
    write_byte(8'hFF, ack); check("ack ptr FF", {31'h0, ack}, 1);
    write_byte(8'hAA, ack); check("ack data AA", {31'h0, ack}, 1);
    write_byte(8'hBB, ack); check("ack data BB", {31'h0, ack}, 1);
    i2c_stop();

    // STOP after 4 data bits: no strobe, bus released, idle.
    i2c_start();
    write_byte(8'hB0, ack); check("ack B0 abort", {31'h0, ack}, 1);
    write_byte(8'h10, ack); check("ack ptr 10", {31'h0, ack}, 1);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    repeat (10) @(posedge clk);
    #1;
    check("sda_oe after abort", {31'h0, sda_oe}, 0);
    check("busy after abort", {31'h0, busy}, 0);

    // Reset mid-read while the target is driving a 0 bit of byte0.
    i2c_start();
    write_byte(8'hB0, ack);
    write_byte(8'h36, ack);
    i2c_start();
    write_byte(8'hB1, ack); check("ack B1 pre-reset", {31'h0, ack}, 1);
    for (int i = 0; i < 3; i++) read_bit(bit_v);
    check("target drives byte0", {31'h0, sda_oe}, 1);
    reset = 1'b0;
    #1;
    check("reset sda_oe async", {31'h0, sda_oe}, 0);
    check("reset busy async", {31'h0, busy}, 0);
    check("reset regs async", {15'h0, reg_wr, reg_addr, reg_data}, 0);
    #50;
    sda_drv = 1'b1;
    scl = 1'b1;
    #30 reset = 1'b1;
    repeat (5) @(posedge clk);

    exp_wr.push_back(16'h4055);
    i2c_start();
    write_byte(8'hB0, ack); check("ack B0 after reset", {31'h0, ack}, 1);
    write_byte(8'h40, ack);
    write_byte(8'h55, ack); check("ack data 55", {31'h0, ack}, 1);
    i2c_stop();
    repeat (10) @(posedge clk);

    check("pending strobes", exp_wr.size(), 0);
    check("pending reads", exp_rd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
